apb_dma_cfg_slave: RTL and testbench
====================================

// Module: apb_dma_cfg_slave
// PURPOSE
//  APB completer that receives transfers driven by the apb_interface master bus and holds the DMA channel
//  configuration: source, destination, length, control and status. It inserts programmable wait states,
//  flags illegal accesses with PSLVERR, pulses dma_start to the DMA engine and captures dma_done as a
//  sticky status bit that raises irq.
// PARAMETERS
//  ADDR_WIDTH   32  PADDR width; only PADDR[4:0] is decoded, upper bits must be 0 or the access errors
//  DATA_WIDTH   32  PWDATA/PRDATA width (fixed 32; other values unsupported)
//  WAIT_STATES  1   access-phase cycles with PREADY=0 before PREADY=1; legal range 0..7
// PORTS
//  PCLK        in   1           APB clock; every flop is on its rising edge
//  PRESETn     in   1           reset, asynchronous and active-low
//  PSEL        in   1           completer select
//  PENABLE     in   1           access phase
//  PWRITE      in   1           1=write, 0=read
//  PADDR       in   ADDR_WIDTH  byte address, word aligned
//  PWDATA      in   DATA_WIDTH  write data
//  PRDATA      out  DATA_WIDTH  read data; valid only while PREADY=1
//  PREADY      out  1           transfer completes this cycle
//  PSLVERR     out  1           error response; valid only while PREADY=1
//  dma_start   out  1           one-cycle start pulse to the DMA engine
//  dma_src     out  32          SRC register
//  dma_dst     out  32          DST register
//  dma_len     out  16          LEN register
//  dma_done    in   1           one-cycle completion pulse from the DMA engine
//  irq         out  1           CTRL.IRQ_EN & STATUS.DONE, registered
// BEHAVIOUR
//  Reset: every register, output and the FSM clear asynchronously to 0 / IDLE, including mid-transfer.
//  Register map:
//   0x00 CTRL    RW   [0] START (write 1 = request, always reads 0); [1] IRQ_EN
//   0x04 SRC     RW   [31:0]
//   0x08 DST     RW   [31:0]
//   0x0C LEN     RW   [15:0]; [31:16] read 0
//   0x10 STATUS  RO/W1C  [0] BUSY (RO); [1] DONE (write 1 to clear)
//  FSM states:
//   IDLE:   PREADY=0. A setup cycle (PSEL=1, PENABLE=0) loads wcnt=WAIT_STATES and goes to ACCESS.
//   ACCESS: PREADY = (wcnt==0), combinational from the register. If wcnt!=0, decrement wcnt.
//           Leave for IDLE on the cycle PSEL&PENABLE&PREADY. If PSEL drops early, abort to IDLE
//           with no side effects.
//  Latency: each transfer takes 2+WAIT_STATES cycles. Back-to-back transfers add no extra idle cycle.
//  Commit: writes and W1C take effect on the completing edge (PSEL&PENABLE&PREADY&PWRITE) and only
//   when there is no error. Reads: PRDATA = the register value in the PREADY cycle, otherwise 0.
//  PSLVERR=1 in the PREADY cycle, with no state change, for any of:
//   - unmapped or unaligned address (PADDR[1:0]!=0, PADDR>0x10, upper bits !=0)
//   - write to SRC/DST/LEN while BUSY
//   - write to CTRL with START=1 while BUSY, or while LEN==0
//  Start: a good CTRL write with START=1 sets BUSY and pulses dma_start for exactly 1 cycle, on the
//   cycle after commit. The IRQ_EN bit from the same write is stored.
//  Done: dma_done=1 clears BUSY and sets DONE. If dma_done and a DONE W1C land in the same cycle,
//   the set wins (DONE=1). dma_done while not BUSY still sets DONE.
//  irq updates 1 cycle after IRQ_EN or DONE changes.
// TESTING
//  1 Reset with WAIT_STATES=1: read 0x04 -> PREADY high in the 3rd cycle, PRDATA=0, PSLVERR=0;
//    irq=0 and dma_start=0 throughout.
//  2 Write SRC=0x1000_0000, DST=0x2000_0000, LEN=0x0040, then CTRL=0x3 -> dma_start pulses once,
//    STATUS reads 0x1; dma_src/dst/len match the values written.
//  3 While BUSY: write LEN=0x80 -> PSLVERR=1 and LEN still reads 0x40. Pulse dma_done -> STATUS=0x2,
//    irq=1 one cycle later. Write STATUS=0x2 -> DONE=0, irq=0.
//  4 Read 0x14 and read 0x06 -> PSLVERR=1, PRDATA=0. CTRL=0x1 with LEN=0 -> PSLVERR=1, no dma_start.
//  5 Sweep WAIT_STATES=0 and 7 -> transfers take 2 and 9 cycles. Drive dma_done in the same cycle as a
//    STATUS W1C commit -> DONE stays 1.
//  6 Assert PRESETn low during an ACCESS wait cycle -> PREADY=0 at once, all registers read 0 after
//    release, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_dma_cfg_slave_if.sv
// APB bus bundle between the requester and the DMA configuration completer.
// PREADY, PRDATA and PSLVERR flow back from the completer.
interface apb_dma_cfg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_dma_cfg_slave.sv
// APB completer holding one DMA channel's configuration and status.
// Inserts wait states, reports PSLVERR, pulses dma_start, latches dma_done.
module apb_dma_cfg_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_dma_cfg_slave_if.slave apb,
  output logic               dma_start,
  output logic [31:0]        dma_src,
  output logic [31:0]        dma_dst,
  output logic [15:0]        dma_len,
  input  logic               dma_done,
  output logic               irq
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t state;
  logic [2:0] wcnt;

  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        irq_en;
  logic        busy;
  logic        done;

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [2:0] idx;
  logic hi_zero;
  logic addr_ok;
  logic sel_ctrl;
  logic sel_src;
  logic sel_dst;
  logic sel_len;
  logic sel_stat;
  logic ready;
  logic setup;
  logic fire;
  logic err;
  logic wr_ok;
  logic go;

  assign addr    = apb.PADDR;
  assign idx     = addr[4:2];
  assign hi_zero = (addr >> 5) == '0;
  assign addr_ok = hi_zero && (addr[1:0] == 2'b00)
                && (idx <= 3'd4);

  assign sel_ctrl = addr_ok && (idx == 3'd0);
  assign sel_src  = addr_ok && (idx == 3'd1);
  assign sel_dst  = addr_ok && (idx == 3'd2);
  assign sel_len  = addr_ok && (idx == 3'd3);
  assign sel_stat = addr_ok && (idx == 3'd4);

  assign ready = (state == ACCESS) && (wcnt == 3'd0);
  assign setup = apb.PSEL && !apb.PENABLE;
  assign fire  = ready && apb.PSEL && apb.PENABLE;

  // Config registers are frozen while a transfer runs.
  always_comb begin
    err = !addr_ok;
    if (addr_ok && apb.PWRITE) begin
      if ((sel_src || sel_dst || sel_len) && busy)
        err = 1'b1;
      if (sel_ctrl && apb.PWDATA[0]
          && (busy || (len == 16'd0)))
        err = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = {30'd0, irq_en, 1'b0};
      sel_src:  rdata = src;
      sel_dst:  rdata = dst;
      sel_len:  rdata = {16'd0, len};
      sel_stat: rdata = {30'd0, done, busy};
      default:  rdata = '0;
    endcase
  end

  assign wr_ok = fire && apb.PWRITE && !err;
  assign go    = wr_ok && sel_ctrl && apb.PWDATA[0];

  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready && err;
  assign apb.PRDATA  = (ready && !err) ? rdata : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      wcnt  <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            wcnt  <= WS;
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            state <= IDLE;
            wcnt  <= 3'd0;
          end else if (fire) begin
            state <= IDLE;
          end else if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      irq_en <= 1'b0;
    end else if (wr_ok) begin
      if (sel_ctrl) irq_en <= apb.PWDATA[1];
      if (sel_src)  src    <= apb.PWDATA;
      if (sel_dst)  dst    <= apb.PWDATA;
      if (sel_len)  len    <= apb.PWDATA[15:0];
    end
  end

  // A completion landing with a W1C keeps DONE set.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dma_start <= 1'b0;
      irq       <= 1'b0;
    end else begin
      dma_start <= go;
      irq       <= irq_en && done;
      if (go)
        busy <= 1'b1;
      else if (dma_done)
        busy <= 1'b0;
      if (dma_done)
        done <= 1'b1;
      else if (wr_ok && sel_stat && apb.PWDATA[1])
        done <= 1'b0;
    end
  end

  assign dma_src = src;
  assign dma_dst = dst;
  assign dma_len = len;

endmodule

// File: tb/tb_apb_dma_cfg_slave.sv
// Bench for apb_dma_cfg_slave: three instances (WAIT_STATES 1, 0, 7)
// driven by directed steps and random traffic against a register model.
module tb_apb_dma_cfg_slave;

  localparam int N = 3;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        rst_n   [N];
  logic        psel    [N];
  logic        penable [N];
  logic        pwrite  [N];
  logic [31:0] paddr   [N];
  logic [31:0] pwdata  [N];
  logic        done_in [N];
  logic        pready  [N];
  logic        pslverr [N];
  logic [31:0] prdata  [N];
  logic        dstart  [N];
  logic        irq_o   [N];
  logic [31:0] dsrc    [N];
  logic [31:0] ddst    [N];
  logic [15:0] dlen    [N];

  for (genvar g = 0; g < N; g++) begin : u
    apb_dma_cfg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.PSEL    = psel[g];
    assign bus.PENABLE = penable[g];
    assign bus.PWRITE  = pwrite[g];
    assign bus.PADDR   = paddr[g];
    assign bus.PWDATA  = pwdata[g];
    assign pready[g]   = bus.PREADY;
    assign pslverr[g]  = bus.PSLVERR;
    assign prdata[g]   = bus.PRDATA;

    apb_dma_cfg_slave #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 7))
    ) dut (
      .PCLK(PCLK),
      .PRESETn(rst_n[g]),
      .apb(bus),
      .dma_start(dstart[g]),
      .dma_src(dsrc[g]),
      .dma_dst(ddst[g]),
      .dma_len(dlen[g]),
      .dma_done(done_in[g]),
      .irq(irq_o[g])
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 7);
  endfunction

  int checks = 0;
  int failures = 0;

  int start_hi [N] = '{0, 0, 0};
  always @(posedge PCLK)
    for (int i = 0; i < N; i++)
      if (dstart[i] === 1'b1) start_hi[i] <= start_hi[i] + 1;

  // Register model, one per instance
  logic [31:0] m_src [N];
  logic [31:0] m_dst [N];
  logic [15:0] m_len [N];
  bit m_ien [N];
  bit m_busy [N];
  bit m_done [N];
  int m_starts [N];

  task automatic m_reset(input int i);
    m_src[i] = 0; m_dst[i] = 0; m_len[i] = 0;
    m_ien[i] = 0; m_busy[i] = 0; m_done[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void predict(input int i, input bit wr,
      input logic [31:0] a, input logic [31:0] d,
      output bit err, output logic [31:0] rd);
    err = 0;
    rd = 0;
    if (a > 32'h10 || a % 4 != 0)
      err = 1;
    else if (wr) begin
      if (a == 32'h0)
        err = d[0] && (m_busy[i] || m_len[i] == 16'h0);
      else if (a != 32'h10)
        err = m_busy[i];
    end
    if (!err)
      case (a)
        32'h00: rd = m_ien[i] ? 32'h2 : 32'h0;
        32'h04: rd = m_src[i];
        32'h08: rd = m_dst[i];
        32'h0C: rd = 32'(m_len[i]);
        32'h10: rd = (m_done[i] ? 32'h2 : 32'h0)
                   + (m_busy[i] ? 32'h1 : 32'h0);
        default: rd = 0;
      endcase
  endfunction

  task automatic apb(input int i, input bit wr, input logic [31:0] a,
      input logic [31:0] d, input bit pulse,
      output logic [31:0] rd, output logic err, output int cyc);
    bit ok;
    psel[i] = 1; penable[i] = 0; pwrite[i] = wr;
    paddr[i] = a; pwdata[i] = d;
    cyc = 1;
    @(posedge PCLK); #1;
    penable[i] = 1;
    cyc = 2;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (pready[i] === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge PCLK); #1;
      cyc++;
    end
    chk("pready_timeout", 32'(ok), 32'd1);
    rd = prdata[i];
    err = pslverr[i];
    if (pulse) done_in[i] = 1;
    @(posedge PCLK); #1;
    psel[i] = 0; penable[i] = 0; done_in[i] = 0;
  endtask

  task automatic xfer(input int i, input bit wr, input logic [31:0] a,
      input logic [31:0] d, input bit pulse, input string tag);
    bit e_err;
    bit e_go;
    logic [31:0] e_rd;
    logic [31:0] rd;
    logic err;
    int cyc;
    predict(i, wr, a, d, e_err, e_rd);
    e_go = wr && !e_err && a == 32'h0 && d[0];
    apb(i, wr, a, d, pulse, rd, err, cyc);
    chk({tag, "_slverr"}, 32'(err), 32'(e_err));
    if (!wr) chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_cycles"}, 32'(cyc), 32'(ws_of(i) + 2));
    chk({tag, "_start"}, 32'(dstart[i]), 32'(e_go));
    if (wr && !e_err)
      case (a)
        32'h00: begin
          m_ien[i] = d[1];
          if (d[0]) begin
            m_busy[i] = 1;
            m_starts[i]++;
          end
        end
        32'h04: m_src[i] = d;
        32'h08: m_dst[i] = d;
        32'h0C: m_len[i] = d[15:0];
        32'h10: if (d[1]) m_done[i] = 0;
        default: ;
      endcase
    if (pulse) begin
      m_busy[i] = 0;
      m_done[i] = 1;
    end
  endtask

  task automatic settle(input int i, input string tag);
    @(posedge PCLK); #1;
    chk({tag, "_start_low"}, 32'(dstart[i]), 32'd0);
    chk({tag, "_start_cnt"}, 32'(start_hi[i]), 32'(m_starts[i]));
    chk({tag, "_irq"}, 32'(irq_o[i]), 32'(m_ien[i] && m_done[i]));
    chk({tag, "_src"}, dsrc[i], m_src[i]);
    chk({tag, "_dst"}, ddst[i], m_dst[i]);
    chk({tag, "_len"}, 32'(dlen[i]), 32'(m_len[i]));
  endtask

  task automatic pulse_done(input int i);
    done_in[i] = 1;
    @(posedge PCLK); #1;
    done_in[i] = 0;
    m_busy[i] = 0;
    m_done[i] = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] atab [9];
    logic [31:0] a;
    logic [31:0] d;
    bit wr;
    atab[0] = 32'h00; atab[1] = 32'h04; atab[2] = 32'h08;
    atab[3] = 32'h0C; atab[4] = 32'h10; atab[5] = 32'h14;
    atab[6] = 32'h06; atab[7] = 32'h100; atab[8] = 32'h8000_0004;

    for (int i = 0; i < N; i++) begin
      rst_n[i] = 0; psel[i] = 0; penable[i] = 0; pwrite[i] = 0;
      paddr[i] = 0; pwdata[i] = 0; done_in[i] = 0;
      m_reset(i);
      m_starts[i] = 0;
    end
    #23;
    for (int i = 0; i < N; i++) rst_n[i] = 1;
    @(posedge PCLK); #1;

    // Reset state and first read
    chk("rst_pready", 32'(pready[0]), 32'd0);
    chk("rst_irq", 32'(irq_o[0]), 32'd0);
    chk("rst_start", 32'(dstart[0]), 32'd0);
    xfer(0, 0, 32'h04, 0, 0, "t1_rd_src");
    settle(0, "t1");

    // Program and start a transfer
    xfer(0, 1, 32'h04, 32'h1000_0000, 0, "t2_src");
    xfer(0, 1, 32'h08, 32'h2000_0000, 0, "t2_dst");
    xfer(0, 1, 32'h0C, 32'h0000_0040, 0, "t2_len");
    xfer(0, 1, 32'h00, 32'h3, 0, "t2_ctrl");
    settle(0, "t2");
    xfer(0, 0, 32'h10, 0, 0, "t2_status");

    // Busy protection, completion and irq
    xfer(0, 1, 32'h0C, 32'h80, 0, "t3_len_busy");
    xfer(0, 0, 32'h0C, 0, 0, "t3_len_rd");
    pulse_done(0);
    chk("t3_irq_lag", 32'(irq_o[0]), 32'd0);
    @(posedge PCLK); #1;
    chk("t3_irq_set", 32'(irq_o[0]), 32'd1);
    xfer(0, 0, 32'h10, 0, 0, "t3_status_done");
    xfer(0, 1, 32'h10, 32'h2, 0, "t3_w1c");
    settle(0, "t3");
    xfer(0, 0, 32'h10, 0, 0, "t3_status_clr");

    // Illegal addresses and START with LEN=0
    xfer(0, 0, 32'h14, 0, 0, "t4_rd_14");
    xfer(0, 0, 32'h06, 0, 0, "t4_rd_06");
    xfer(0, 1, 32'h0C, 32'h0, 0, "t4_len0");
    xfer(0, 1, 32'h00, 32'h1, 0, "t4_ctrl_len0");
    settle(0, "t4");

    // Latency sweep, back-to-back, W1C against dma_done
    xfer(1, 0, 32'h04, 0, 0, "t5_ws0_a");
    xfer(1, 0, 32'h08, 0, 0, "t5_ws0_b");
    xfer(2, 0, 32'h04, 0, 0, "t5_ws7_a");
    xfer(2, 0, 32'h0C, 0, 0, "t5_ws7_b");
    pulse_done(1);
    xfer(1, 1, 32'h10, 32'h2, 1, "t5_w1c_race");
    xfer(1, 0, 32'h10, 0, 0, "t5_status");
    settle(1, "t5");

    // Random traffic on every instance
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 40; n++) begin
        a = atab[$urandom_range(0, 8)];
        wr = 1'($urandom_range(0, 1));
        d = $urandom;
        if (a == 32'h0C && ($urandom_range(0, 3) == 0))
          d = 32'h0;
        xfer(i, wr, a, d, 0, "rnd");
        settle(i, "rnd");
        if (m_busy[i] && $urandom_range(0, 2) == 0)
          pulse_done(i);
      end

    // Reset in the middle of a wait cycle
    psel[2] = 1; penable[2] = 0; pwrite[2] = 0; paddr[2] = 32'h04;
    @(posedge PCLK); #1;
    penable[2] = 1;
    @(posedge PCLK); #1;
    rst_n[2] = 0;
    #1;
    chk("t6_pready", 32'(pready[2]), 32'd0);
    chk("t6_irq", 32'(irq_o[2]), 32'd0);
    chk("t6_src", dsrc[2], 32'd0);
    psel[2] = 0; penable[2] = 0;
    m_reset(2);
    @(posedge PCLK); #1;
    rst_n[2] = 1;
    @(posedge PCLK); #1;
    xfer(2, 0, 32'h00, 0, 0, "t6_ctrl");
    xfer(2, 0, 32'h04, 0, 0, "t6_src");
    xfer(2, 0, 32'h08, 0, 0, "t6_dst");
    xfer(2, 0, 32'h0C, 0, 0, "t6_len");
    xfer(2, 0, 32'h10, 0, 0, "t6_status");
    xfer(2, 1, 32'h04, 32'hCAFE_0004, 0, "t6_wr");
    xfer(2, 0, 32'h04, 0, 0, "t6_rd");
    settle(2, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
